// File: rtl/inst_buffer_pkg.sv
// inst_buffer_pkg: entry layout and default geometry of the fetch-to-decode instruction buffer.
package inst_buffer_pkg;
  localparam int IB_ENTRY_WD = 67;
  localparam int IB_PC_HI = 66;
  localparam int IB_PC_LO = 35;
  localparam int IB_INST_HI = 34;
  localparam int IB_INST_LO = 3;
  localparam int IB_EXC_HI = 2;
  localparam int IB_EXC_LO = 0;
  localparam int IB_EXC_WD = 3;
  localparam int IB_DEPTH = 16;
  localparam int IB_WR_PORTS = 2;
  localparam int IB_RD_PORTS = 2;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [IB_EXC_WD-1:0] exc;
  } ib_entry_t;
endpackage

// File: rtl/inst_buffer_ram.sv
// inst_buffer_ram: circular register array, multi-port write at consecutive slots, async multi-port read.
module inst_buffer_ram
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = IB_DEPTH,
  parameter int WR_PORTS = IB_WR_PORTS,
  parameter int RD_PORTS = IB_RD_PORTS,
  parameter int WD = IB_ENTRY_WD
) (
  input  logic                        clk_i,
  input  logic [WR_PORTS-1:0]         we_i,
  input  logic [$clog2(DEPTH)-1:0]    waddr_i,
  input  logic [WR_PORTS*WD-1:0]      wdata_i,
  input  logic [$clog2(DEPTH)-1:0]    raddr_i,
  output logic [RD_PORTS*WD-1:0]      rdata_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WD-1:0] mem_q [DEPTH];
  // Addresses wrap naturally by truncation to AW bits since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < WR_PORTS; i++)
      if (we_i[i]) mem_q[waddr_i + AW'(i)] <= wdata_i[i*WD +: WD];
  end
  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    assign rdata_o[i*WD +: WD] = mem_q[raddr_i + AW'(i)];
  end
endmodule

// File: rtl/inst_buffer.sv
// inst_buffer: IF-to-IDIS circular FIFO with grouped writes, variable clamped pops and flush.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = IB_DEPTH,
  parameter int WR_PORTS = IB_WR_PORTS,
  parameter int RD_PORTS = IB_RD_PORTS,
  parameter int ENTRY_WD = IB_ENTRY_WD
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic [WR_PORTS-1:0]                wr_valid,
  input  logic [WR_PORTS*ENTRY_WD-1:0]       wr_data,
  output logic                               wr_ready,
  output logic [RD_PORTS-1:0]                rd_valid,
  output logic [RD_PORTS*ENTRY_WD-1:0]       rd_data,
  input  logic [$clog2(RD_PORTS+1)-1:0]      rd_pop,
  output logic [$clog2(DEPTH+1)-1:0]         count,
  output logic                               empty,
  output logic                               full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, wr_n, wr_n_acc, pop_lim, pop_n;
  logic [WR_PORTS-1:0] wr_en, wr_valid_inc;
  logic accept;
  always_comb begin
    wr_n = '0;
    for (int i = 0; i < WR_PORTS; i++) wr_n = wr_n + CW'(wr_valid[i]);
  end
  // Ready looks only at registered occupancy so it never depends on rd_pop.
  assign wr_ready = count_q <= CW'(DEPTH - WR_PORTS);
  assign accept = wr_ready && !flush;
  assign wr_n_acc = accept ? wr_n : '0;
  for (genvar i = 0; i < WR_PORTS; i++) begin : g_we
    assign wr_en[i] = accept && (CW'(i) < wr_n);
  end
  assign pop_lim = count_q < CW'(RD_PORTS) ? count_q : CW'(RD_PORTS);
  assign pop_n = flush ? '0 : (CW'(rd_pop) < pop_lim ? CW'(rd_pop) : pop_lim);
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(wr_n_acc);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop_n);
    count_d = flush ? '0 : count_q + wr_n_acc - pop_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rv
    assign rd_valid[i] = count_q > CW'(i);
  end
  assign count = count_q;
  assign empty = count_q == '0;
  assign full = count_q == CW'(DEPTH);
  inst_buffer_ram #(
    .DEPTH(DEPTH), .WR_PORTS(WR_PORTS), .RD_PORTS(RD_PORTS), .WD(ENTRY_WD)
  ) u_ram (
    .clk_i(clk), .we_i(wr_en), .waddr_i(wr_ptr_q), .wdata_i(wr_data),
    .raddr_i(rd_ptr_q), .rdata_o(rd_data)
  );
  assign wr_valid_inc = wr_valid + WR_PORTS'(1);
  a_thermo: assert property (@(posedge clk) disable iff (reset) (wr_valid & wr_valid_inc) == '0);
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: directed scenario bench for inst_buffer at DEPTH=16, 2 write / 2 read ports.
module tb_inst_buffer;
  localparam int W = 67;
  logic clk = 0, reset = 1, flush = 0;
  logic [1:0] wr_valid = 0, rd_valid, rd_pop = 0;
  logic [2*W-1:0] wr_data = 0, rd_data;
  logic wr_ready, empty, full;
  logic [4:0] count;
  int n_cmp = 0, n_fail = 0;
  logic [31:0] p_w, p_r;

  inst_buffer #(.DEPTH(16), .WR_PORTS(2), .RD_PORTS(2), .ENTRY_WD(W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_pop(rd_pop),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ent(input logic [31:0] pc, input logic [31:0] inst);
    return {pc, inst, 3'b000};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
    wr_valid = v;
    wr_data = {ent(pc1, ~pc1), ent(pc0, ~pc0)};
  endtask

  task automatic idle();
    wr_valid = 0;
    rd_pop = 0;
    flush = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    n_cmp++; if (rd_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rd_valid got %b want 00", rd_valid); end
  endtask

  task automatic test_write_pair();
    do_reset();
    wr_valid = 2'b11;
    wr_data = {32'hbfc00004, 32'h24090002, 3'b000, 32'hbfc00000, 32'h24080001, 3'b000};
    tick();
    idle();
    n_cmp++; if (count !== 5'd2) begin n_fail++; $display("FAIL pair_count got %0d want 2", count); end
    n_cmp++; if (rd_valid !== 2'b11) begin n_fail++; $display("FAIL pair_rd_valid got %b want 11", rd_valid); end
    n_cmp++; if (rd_data[66:35] !== 32'hbfc00000) begin n_fail++; $display("FAIL pair_pc0 got %h want bfc00000", rd_data[66:35]); end
    n_cmp++; if (rd_data[W+34:W+3] !== 32'h24090002) begin n_fail++; $display("FAIL pair_inst1 got %h want 24090002", rd_data[W+34:W+3]); end
    n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL pair_empty got %b want 0", empty); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      put(2'b11, 32'h100 + 32'(8*k), 32'h104 + 32'(8*k));
      tick();
    end
    put(2'b01, 32'h138, 32'h0);
    tick();
    idle();
    n_cmp++; if (count !== 5'd15) begin n_fail++; $display("FAIL fill_count got %0d want 15", count); end
    n_cmp++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL fill_wr_ready got %b want 0", wr_ready); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL fill_full got %b want 0", full); end
    put(2'b11, 32'hdead0000, 32'hdead0004);
    tick();
    idle();
    n_cmp++; if (count !== 5'd15) begin n_fail++; $display("FAIL fill_ignored got %0d want 15", count); end
    rd_pop = 2'd1;
    tick();
    idle();
    n_cmp++; if (count !== 5'd14) begin n_fail++; $display("FAIL fill_pop_count got %0d want 14", count); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL fill_pop_ready got %b want 1", wr_ready); end
    n_cmp++; if (rd_data[66:35] !== 32'h104) begin n_fail++; $display("FAIL fill_head got %h want 104", rd_data[66:35]); end
    put(2'b11, 32'h13c, 32'h140);
    tick();
    idle();
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full16 got %b want 1", full); end
    n_cmp++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready16 got %b want 0", wr_ready); end
    rd_pop = 2'd3;
    tick();
    idle();
    n_cmp++; if (count !== 5'd14) begin n_fail++; $display("FAIL overpop_count got %0d want 14", count); end
    n_cmp++; if (rd_data[66:35] !== 32'h10c) begin n_fail++; $display("FAIL overpop_head got %h want 10c", rd_data[66:35]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    put(2'b11, 32'h1000, 32'h1004);
    tick();
    put(2'b01, 32'h1008, 32'h0);
    tick();
    idle();
    n_cmp++; if (count !== 5'd3) begin n_fail++; $display("FAIL b2b_start got %0d want 3", count); end
    p_w = 32'h100c;
    p_r = 32'h1000;
    for (int c = 0; c < 20; c++) begin
      n_cmp++; if (rd_data[66:35] !== p_r) begin n_fail++; $display("FAIL b2b_pc0 cyc %0d got %h want %h", c, rd_data[66:35], p_r); end
      n_cmp++; if (rd_data[W+66:W+35] !== p_r + 4) begin n_fail++; $display("FAIL b2b_pc1 cyc %0d got %h want %h", c, rd_data[W+66:W+35], p_r + 4); end
      put(2'b11, p_w, p_w + 4);
      rd_pop = 2'd2;
      tick();
      p_w += 8;
      p_r += 8;
      n_cmp++; if (count !== 5'd3) begin n_fail++; $display("FAIL b2b_count cyc %0d got %0d want 3", c, count); end
    end
    idle();
  endtask

  task automatic test_clamp();
    do_reset();
    put(2'b01, 32'h2000, 32'h0);
    tick();
    put(2'b11, 32'h3000, 32'h3004);
    rd_pop = 2'd2;
    tick();
    idle();
    n_cmp++; if (count !== 5'd2) begin n_fail++; $display("FAIL clamp_count got %0d want 2", count); end
    n_cmp++; if (rd_data[66:35] !== 32'h3000) begin n_fail++; $display("FAIL clamp_pc0 got %h want 3000", rd_data[66:35]); end
    n_cmp++; if (rd_data[W+66:W+35] !== 32'h3004) begin n_fail++; $display("FAIL clamp_pc1 got %h want 3004", rd_data[W+66:W+35]); end
  endtask

  task automatic test_flush();
    do_reset();
    put(2'b11, 32'h4000, 32'h4004); tick();
    put(2'b11, 32'h4008, 32'h400c); tick();
    put(2'b01, 32'h4010, 32'h0); tick();
    idle();
    n_cmp++; if (count !== 5'd5) begin n_fail++; $display("FAIL flush_pre got %0d want 5", count); end
    flush = 1;
    put(2'b11, 32'h5000, 32'h5004);
    rd_pop = 2'd2;
    tick();
    idle();
    n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty got %b want 1", empty); end
    n_cmp++; if (rd_valid !== 2'b00) begin n_fail++; $display("FAIL flush_rd_valid got %b want 00", rd_valid); end
    put(2'b01, 32'h80000180, 32'h0);
    tick();
    idle();
    n_cmp++; if (rd_data[66:35] !== 32'h80000180) begin n_fail++; $display("FAIL flush_post_pc got %h want 80000180", rd_data[66:35]); end
    n_cmp++; if (rd_valid !== 2'b01) begin n_fail++; $display("FAIL flush_post_valid got %b want 01", rd_valid); end
    put(2'b11, 32'h6000, 32'h6004);
    reset = 1;
    tick();
    reset = 0;
    idle();
    n_cmp++; if (rd_valid !== 2'b00) begin n_fail++; $display("FAIL midreset_rd_valid got %b want 00", rd_valid); end
    n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL midreset_count got %0d want 0", count); end
  endtask

  initial begin
    test_reset();
    test_write_pair();
    test_fill();
    test_back_to_back();
    test_clamp();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Parametrised instruction buffer between the IF stage and the IDIS (decode/issue) stage of the dual-issue core.
- Generalises the fixed single-write, two-line buffer to a circular FIFO with WR_PORTS entries written per cycle and RD_PORTS entries read per cycle.
- Supports a variable pop count and a flush on branch mispredict or exception.
- Entries carry {pc, inst, exc}. Decode consumes 0..RD_PORTS entries per cycle.

Parameters:
DEPTH, 16, number of entries; power of 2, must be >= WR_PORTS + RD_PORTS.
WR_PORTS, 2, max entries written per cycle (fetch group width).
RD_PORTS, 2, max entries exposed and popped per cycle (issue width).
ENTRY_WD, 67, entry width: pc[66:35], inst[34:3], exc[2:0].

Ports:
clk  in  1  clock.
reset  in  1  synchronous active-high reset.
flush  in  1  discard all contents.
wr_valid  in  WR_PORTS  per-slot write valid; must be thermometer-coded from bit 0.
wr_data  in  WR_PORTS*ENTRY_WD  slot i occupies bits [i*ENTRY_WD +: ENTRY_WD].
wr_ready  out  1  buffer can accept a full group: free slots >= WR_PORTS.
rd_valid  out  RD_PORTS  rd_valid[i] = (count > i).
rd_data  out  RD_PORTS*ENTRY_WD  entry at rd_ptr+i (mod DEPTH) for slot i.
rd_pop  in  clog2(RD_PORTS+1)  number of head entries consumed this cycle.
count  out  clog2(DEPTH+1)  current occupancy.
empty  out  1  count == 0.
full  out  1  count == DEPTH.

Behaviour:
- State: wr_ptr and rd_ptr, clog2(DEPTH) bits each, wrapping mod DEPTH; count register; storage array.
- Reset: wr_ptr = rd_ptr = count = 0. Outputs: empty=1, full=0, wr_ready=1, rd_valid=0. rd_data is don't-care while rd_valid=0. Array contents are not reset.
- Write:
  - Accepted when wr_ready=1. wr_n = popcount(wr_valid).
  - Slot i is written to mem[wr_ptr+i]. wr_ptr advances by wr_n.
  - When wr_ready=0, writes are ignored and the producer must hold them.
- wr_ready timing:
  - Computed from the registered count only. Slots freed by a pop in the same cycle are not reusable until the next cycle.
  - wr_ready is not combinationally dependent on rd_pop.
- Read:
  - rd_data and rd_valid are combinational from the registered array and pointers.
  - Zero-latency visibility: a write in cycle N appears on rd_data in cycle N+1.
- Pop:
  - pop_n = min(rd_pop, count, RD_PORTS); illegal over-pops are clamped, not errored.
  - rd_ptr advances by pop_n.
- Occupancy: count_next = count + wr_n_accepted - pop_n. A simultaneous write and pop is always legal.
- Ordering: entries pop strictly in write order, including across pointer wrap (e.g. wr_ptr 15 -> 1 on a 2-write).
- Non-thermometer wr_valid (e.g. 2'b10) is a protocol violation. Simulation assertion fires; RTL writes only the low popcount slots.
- Flush:
  - Next cycle: wr_ptr = rd_ptr = count = 0.
  - Writes and pops presented in the flush cycle are discarded.
  - The first post-flush write appears at rd_data slot 0.
- Priority: reset > flush > normal operation.
- Reset or flush mid-stream (buffer partly full) behaves identically to empty: no stale rd_valid in the following cycle.
- Registers: no registered output beyond count, full and empty. full and empty may be decoded from count.

Decomposition:
- Shared package (mycpu.h defines):
  - IB_ENTRY_WD = 67.
  - Field offsets: IB_PC_HI/LO, IB_INST_HI/LO, IB_EXC_HI/LO.
  - Exc code width = 3.
  - Default DEPTH and port counts.
- Sub-module inst_buffer_ram: DEPTH x ENTRY_WD register array with WR_PORTS write ports and RD_PORTS asynchronous read ports, using modular address arithmetic.
- inst_buffer keeps the pointers, count, clamp and flush control.

Test Plan:
(All cases use DEPTH=16, WR_PORTS=2, RD_PORTS=2.)
1. Release reset, no traffic -> count=0, empty=1, full=0, wr_ready=1, rd_valid=2'b00.
2. Write pc 0xbfc00000/0xbfc00004, inst 0x24080001/0x24090002, wr_valid=2'b11 -> next cycle count=2, rd_valid=2'b11, rd_data[0].pc=0xbfc00000, rd_data[1].inst=0x24090002.
3. Fill with 2-writes, no pops:
   - after 7 groups plus one wr_valid=2'b01 write: count=15, wr_ready=0;
   - a further write is ignored and count stays 15;
   - then pop 1 -> count=14, wr_ready=1 in the following cycle.
4. Steady state of write 2 + pop 2 per cycle for 20 cycles, starting at count=3 with sequential pcs -> count stays 3, popped pcs strictly increasing by 4, pointers wrap 15->0 with no loss or duplication.
5. count=1, rd_pop=2 with simultaneous wr_valid=2'b11 -> pop clamped to 1, next count=2, rd_data[0] = first new entry.
6. count=5, assert flush with wr_valid=2'b11 and rd_pop=2 -> next cycle count=0, empty=1, rd_valid=0. The following write of pc 0x80000180 shows at rd_data[0] one cycle later.
